// File: rtl/int_to_fp_sched_if.sv
// Handshake bundle for int_to_fp_sched: requester operand ports and the tagged result port.
// The master modport is the requester/consumer side; the slave modport is the scheduler.
interface int_to_fp_sched_if #(
  parameter int unsigned NUM_REQ = 4,
  parameter int unsigned ID_W    = 2
);
  logic [NUM_REQ-1:0]   req_valid;
  logic [8*NUM_REQ-1:0] req_data;
  logic [NUM_REQ-1:0]   req_ready;
  logic                 res_valid;
  logic                 res_ready;
  logic [ID_W-1:0]      res_id;
  logic                 res_sign;
  logic [3:0]           res_exp;
  logic [7:0]           res_frac;

  modport master (
    output req_valid, req_data, res_ready,
    input  req_ready, res_valid, res_id, res_sign, res_exp, res_frac
  );

  modport slave (
    input  req_valid, req_data, res_ready,
    output req_ready, res_valid, res_id, res_sign, res_exp, res_frac
  );
endinterface

// File: rtl/int_to_fp_sched.sv
// Round-robin scheduler sharing one int_to_fp converter among NUM_REQ requesters.
// Optional completed-result counter (conv_count) is built when FP_CONV_CNT_EN is defined.
module int_to_fp_sched #(
  parameter int unsigned NUM_REQ = 4,
  parameter int unsigned ID_W    = 2
) (
  input logic             clk,
  input logic             reset_n,
  int_to_fp_sched_if.slave bus
`ifdef FP_CONV_CNT_EN
  ,
  output logic [15:0]     conv_count
`endif
);

  typedef enum logic [1:0] {StIdle, StConv, StHold} state_e;

  state_e          state_q, state_d;
  logic [ID_W-1:0] ptr_q;
  logic [7:0]      opnd_q;
  logic [ID_W-1:0] res_id_q;
  logic            res_sign_q;
  logic [3:0]      res_exp_q;
  logic [7:0]      res_frac_q;

  logic            grant_found;
  logic [ID_W-1:0] grant_id;
  logic [ID_W-1:0] cand;
  logic            res_hs;

  logic            conv_sign;
  logic [7:0]      conv_mag;
  logic [3:0]      conv_exp;
  logic [7:0]      conv_frac;

  // Search starts one past the last grant so every holder is served within NUM_REQ-1 grants.
  always_comb begin
    grant_found = 1'b0;
    grant_id    = '0;
    cand        = '0;
    for (int i = 1; i <= int'(NUM_REQ); i++) begin
      cand = ID_W'((int'(ptr_q) + i) % int'(NUM_REQ));
      if (!grant_found && bus.req_valid[cand]) begin
        grant_found = 1'b1;
        grant_id    = cand;
      end
    end
  end

  // int_to_fp: magnitude normalised so its leading one sits in frac[7]; exp is its bit length.
  always_comb begin
    conv_sign = opnd_q[7];
    conv_mag  = conv_sign ? (~opnd_q + 8'd1) : opnd_q;
    conv_exp  = '0;
    for (int b = 0; b < 8; b++) begin
      if (conv_mag[b]) conv_exp = 4'(b + 1);
    end
    conv_frac = conv_mag << (4'd8 - conv_exp);
  end

  always_ff @(posedge clk) begin
    if (!reset_n) begin
      state_q <= StIdle;
    end else begin
      state_q <= state_d;
    end
  end

  always_comb begin
    state_d = state_q;
    unique case (state_q)
      StIdle:  if (grant_found) state_d = StConv;
      StConv:  state_d = StHold;
      StHold:  if (bus.res_ready) state_d = StIdle;
      default: state_d = StIdle;
    endcase
  end

  always_comb begin
    bus.req_ready = '0;
    if (state_q == StIdle && grant_found) bus.req_ready[grant_id] = 1'b1;
    bus.res_valid = (state_q == StHold);
    bus.res_id    = res_id_q;
    bus.res_sign  = res_sign_q;
    bus.res_exp   = res_exp_q;
    bus.res_frac  = res_frac_q;
  end

  assign res_hs = (state_q == StHold) && bus.res_ready;

  // ptr_q doubles as the owner id of the latched operand.
  always_ff @(posedge clk) begin
    if (!reset_n) begin
      ptr_q      <= ID_W'(NUM_REQ - 1);
      opnd_q     <= '0;
      res_id_q   <= '0;
      res_sign_q <= 1'b0;
      res_exp_q  <= '0;
      res_frac_q <= '0;
    end else begin
      if (state_q == StIdle && grant_found) begin
        ptr_q  <= grant_id;
        opnd_q <= bus.req_data[8*grant_id +: 8];
      end
      if (state_q == StConv) begin
        res_id_q   <= ptr_q;
        res_sign_q <= conv_sign;
        res_exp_q  <= conv_exp;
        res_frac_q <= conv_frac;
      end
    end
  end

`ifdef FP_CONV_CNT_EN
  logic [15:0] cnt_q;

  always_ff @(posedge clk) begin
    if (!reset_n) begin
      cnt_q <= '0;
    end else if (res_hs && cnt_q != 16'hFFFF) begin
      cnt_q <= cnt_q + 16'd1;
    end
  end

  assign conv_count = cnt_q;
`else
  logic unused_hs;
  assign unused_hs = res_hs;
`endif

endmodule

// File: tb/tb_int_to_fp_sched.sv
// Self-checking bench for int_to_fp_sched: per-cycle compare against a transaction-level model
// plus directed scenarios with literal expectations.
module tb_int_to_fp_sched;
  localparam int unsigned N  = 4;
  localparam int unsigned IW = 2;

  logic clk = 1'b0;
  logic reset_n = 1'b0;
  always #5 clk = ~clk;

  int_to_fp_sched_if #(.NUM_REQ(N), .ID_W(IW)) bus ();
`ifdef FP_CONV_CNT_EN
  logic [15:0] conv_count;
`endif

  int_to_fp_sched #(.NUM_REQ(N), .ID_W(IW)) dut (
    .clk        (clk),
    .reset_n    (reset_n),
    .bus        (bus)
`ifdef FP_CONV_CNT_EN
    ,
    .conv_count (conv_count)
`endif
  );

  int tests = 0;
  int fails = 0;

  // Reference conversion: value = frac/256 * 2^exp, frac normalised with its top bit set.
  function automatic logic [12:0] ref_conv(logic [7:0] x);
    int v, mag, e;
    v   = int'($signed(x));
    mag = (v < 0) ? -v : v;
    e   = 0;
    while ((1 << e) <= mag) e++;
    return {(v < 0) ? 1'b1 : 1'b0, 4'(e), 8'(mag * (1 << (8 - e)))};
  endfunction

  function automatic int ref_grant(logic [N-1:0] v, int p);
    for (int k = 1; k <= int'(N); k++) begin
      if (v[(p + k) % int'(N)]) return (p + k) % int'(N);
    end
    return -1;
  endfunction

  task automatic chk(string name, logic [31:0] act, logic [31:0] exp);
    tests++;
    if (act !== exp) begin
      fails++;
      $display("FAIL %s actual=%0h required=%0h", name, act, exp);
    end
  endtask

  // Model: phase 0 = waiting for a request, 1 = converting, 2 = offering the result.
  int            m_phase = 0;
  int            m_ptr = N - 1;
  int            m_g;
  logic [7:0]    m_opnd;
  logic [IW-1:0] m_id;
  logic [12:0]   m_res;
  int            m_cnt = 0;
  bit            chk_en = 0;

  always @(posedge clk) begin
    if (!reset_n) begin
      m_phase = 0;
      m_ptr   = N - 1;
      m_id    = '0;
      m_res   = '0;
      m_cnt   = 0;
      chk_en  = 1;
    end else begin
      case (m_phase)
        0: begin
          m_g = ref_grant(bus.req_valid, m_ptr);
          if (m_g >= 0) begin
            m_ptr   = m_g;
            m_opnd  = bus.req_data[8*m_g +: 8];
            m_phase = 1;
          end
        end
        1: begin
          m_res   = ref_conv(m_opnd);
          m_id    = IW'(m_ptr);
          m_phase = 2;
        end
        default: begin
          if (bus.res_ready) begin
            m_phase = 0;
            if (m_cnt < 65535) m_cnt++;
          end
        end
      endcase
    end
  end

  logic [N-1:0] exp_rdy;
  logic [35:0]  exp_v, act_v;
  int           c_g;

  always @(negedge clk) begin
    if (chk_en) begin
      exp_rdy = '0;
      if (m_phase == 0) begin
        c_g = ref_grant(bus.req_valid, m_ptr);
        if (c_g >= 0) exp_rdy[c_g] = 1'b1;
      end
`ifdef FP_CONV_CNT_EN
      exp_v = 36'({exp_rdy, m_phase == 2, m_id, m_res, 16'(m_cnt)});
      act_v = 36'({bus.req_ready, bus.res_valid, bus.res_id, bus.res_sign, bus.res_exp,
                   bus.res_frac, conv_count});
`else
      exp_v = 36'({exp_rdy, m_phase == 2, m_id, m_res});
      act_v = 36'({bus.req_ready, bus.res_valid, bus.res_id, bus.res_sign, bus.res_exp,
                   bus.res_frac});
`endif
      tests++;
      if (act_v !== exp_v) begin
        fails++;
        $display("FAIL cycle_check t=%0t actual=%h required=%h", $time, act_v, exp_v);
      end
    end
  end

  // Stimulus bookkeeping
  bit            hold_valid = 0;
  int            hs = 0;
  logic [IW-1:0] hs_ids[$];
  logic [12:0]   hs_res;
  logic [N-1:0]  last_rdy;
  logic          last_rv;
  logic [IW-1:0] last_id;
  logic [12:0]   last_res;
  logic [15:0]   last_cnt = '0;

  task automatic tick();
    logic [N-1:0] acc;
    @(negedge clk);
    acc      = bus.req_valid & bus.req_ready;
    last_rdy = bus.req_ready;
    last_rv  = bus.res_valid;
    last_id  = bus.res_id;
    last_res = {bus.res_sign, bus.res_exp, bus.res_frac};
`ifdef FP_CONV_CNT_EN
    last_cnt = conv_count;
`endif
    if (bus.res_valid && bus.res_ready) begin
      hs++;
      hs_ids.push_back(bus.res_id);
      hs_res = {bus.res_sign, bus.res_exp, bus.res_frac};
    end
    @(posedge clk);
    #1;
    if (!hold_valid) bus.req_valid = bus.req_valid & ~acc;
  endtask

  task automatic offer(int i, logic [7:0] d);
    bus.req_data[8*i +: 8] = d;
    bus.req_valid[i]       = 1'b1;
  endtask

  task automatic run_until_hs(int target, string name);
    int n = 0;
    while (hs < target && n < 40) begin
      tick();
      n++;
    end
    chk(name, hs, target);
  endtask

  initial begin
    int n;
    int base;
    bus.req_valid = '0;
    bus.req_data  = '0;
    bus.res_ready = 1'b1;

    // Pin the model against hand-computed values
    chk("model_conv_05", 32'(ref_conv(8'h05)), {19'd0, 1'b0, 4'd3, 8'hA0});
    chk("model_conv_m128", 32'(ref_conv(8'h80)), {19'd0, 1'b1, 4'd8, 8'h80});
    chk("model_conv_m1", 32'(ref_conv(8'hFF)), {19'd0, 1'b1, 4'd1, 8'h80});
    chk("model_conv_7f", 32'(ref_conv(8'h7F)), {19'd0, 1'b0, 4'd7, 8'hFE});
    chk("model_conv_0", 32'(ref_conv(8'h00)), 32'd0);
    chk("model_grant_wrap", ref_grant(4'b1111, 3), 0);
    chk("model_grant_skip", ref_grant(4'b0101, 0), 2);

    // 1: reset held for two edges
    @(posedge clk);
    #1;
    tick();
    tick();
    chk("reset_res_valid", last_rv, 0);
    chk("reset_req_ready", last_rdy, 0);
    chk("reset_res_id", last_id, 0);
    chk("reset_result", last_res, 0);
    chk("reset_conv_count", last_cnt, 0);
    reset_n = 1'b1;

    // 2: requester 0 offers 5
    offer(0, 8'h05);
    tick();
    chk("t2_accept_ready", last_rdy, 4'b0001);
    tick();
    chk("t2_conv_valid", last_rv, 0);
    tick();
    chk("t2_res_valid", last_rv, 1);
    chk("t2_res_id", last_id, 0);
    chk("t2_result", last_res, {1'b0, 4'd3, 8'hA0});

    // 3: requester 2 offers 0
    offer(2, 8'h00);
    run_until_hs(2, "t3_hs");
    chk("t3_res_id", hs_ids[1], 2);
    chk("t3_result", hs_res, 0);

    // Requester 3 offers -1, leaving the pointer on 3
    offer(3, 8'hFF);
    run_until_hs(3, "t3b_hs");
    chk("t3b_res_id", hs_ids[2], 3);
    chk("t3b_result", hs_res, {1'b1, 4'd1, 8'h80});

    // 4: all four hold valid continuously
    offer(0, 8'h05);
    offer(1, 8'h80);
    offer(2, 8'h7F);
    offer(3, 8'hFD);
    hold_valid = 1;
    run_until_hs(8, "t4_hs");
    hold_valid    = 0;
    bus.req_valid = '0;
    chk("t4_order0", hs_ids[3], 0);
    chk("t4_order1", hs_ids[4], 1);
    chk("t4_order2", hs_ids[5], 2);
    chk("t4_order3", hs_ids[6], 3);
    chk("t4_order4", hs_ids[7], 0);
    chk("t4_last_result", hs_res, {1'b0, 4'd3, 8'hA0});

    // 5: consumer stalls for 10 cycles in HOLD
    bus.res_ready = 1'b0;
    offer(1, 8'h03);
    tick();
    n = 0;
    tick();
    while (!last_rv && n < 10) begin
      tick();
      n++;
    end
    chk("t5_reach_hold", last_rv, 1);
    offer(3, 8'h40);
    repeat (10) tick();
    chk("t5_still_valid", last_rv, 1);
    chk("t5_no_ready", last_rdy, 0);
    chk("t5_res_id", last_id, 1);
    chk("t5_result", last_res, {1'b0, 4'd2, 8'hC0});
    chk("t5_no_hs", hs, 8);
    bus.res_ready = 1'b1;
    tick();
    chk("t5_one_hs", hs, 9);
    tick();
    chk("t5_exactly_one", hs, 9);
    run_until_hs(10, "t5_next_hs");
    chk("t5_next_id", hs_ids[9], 3);
    chk("t5_next_result", hs_res, {1'b0, 4'd7, 8'h80});

    // 6: reset pulsed while converting
    offer(1, 8'h11);
    tick();
    chk("t6_accept", last_rdy, 4'b0010);
    reset_n = 1'b0;
    tick();
    reset_n = 1'b1;
    repeat (3) tick();
    chk("t6_no_result", hs, 10);
    chk("t6_no_valid", last_rv, 0);
    base = hs;
    offer(0, 8'h22);
    offer(2, 8'h33);
    tick();
    chk("t6_prio0", last_rdy, 4'b0001);
    run_until_hs(base + 2, "t6_hs");
    chk("t6_first_id", hs_ids[10], 0);
    chk("t6_second_id", hs_ids[11], 2);
    offer(3, 8'hC8);
    run_until_hs(base + 3, "t6_third_hs");
    tick();
`ifdef FP_CONV_CNT_EN
    chk("cnt_three", last_cnt, 3);
`endif

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
